// File: rtl/trng_pkg.sv
// Shared types and helpers for the GARO random-word controller.
package trng_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WARM    = 3'd1,
      COLLECT = 3'd2,
      HOLD    = 3'd3,
      FAULT   = 3'd4
   } state_e;

   // Counter width able to hold the value p itself (never wraps).
   function automatic int unsigned cnt_w(input int unsigned p);
      return $clog2(p) + 1;
   endfunction

endpackage

// File: rtl/trng_ctrl_if.sv
// Request/word handshake plus oscillator control between trng_ctrl and its users.
interface trng_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req;
   logic             rnd_bit;
   logic             ack;
   logic             osc_en;
   logic             valid;
   logic             fault;
   logic [WIDTH-1:0] data;

   // Consumer / oscillator side.
   modport master (output req, rnd_bit, ack, input osc_en, valid, fault, data);
   // Controller side.
   modport slave  (input req, rnd_bit, ack, output osc_en, valid, fault, data);
endinterface

// File: rtl/trng_ctrl_vn_debias.sv
// Von Neumann corrector over non-overlapping raw sample pairs.
module vn_debias (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic sample_stb,
   input  logic sample,
   output logic bit_stb,
   output logic bit_out
);

   logic first_q, first_d;
   logic flag_q, flag_d;

   // Store first sample of a pair; second sample always closes the pair.
   always_comb begin
      first_d = first_q;
      flag_d  = flag_q;
      if (clear) begin
         flag_d = 1'b0;
      end else if (sample_stb) begin
         if (!flag_q) begin
            first_d = sample;
            flag_d  = 1'b1;
         end else begin
            flag_d  = 1'b0;
         end
      end
   end

   // Pair register and flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         first_q <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         first_q <= first_d;
         flag_q  <= flag_d;
      end
   end

   // 10 emits 1, 01 emits 0; 00 and 11 emit nothing.
   assign bit_stb = sample_stb & flag_q & (first_q ^ sample);
   assign bit_out = first_q;

endmodule

// File: rtl/trng_ctrl.sv
// GARO sequencing: warm-up, paced sampling, debias, repetition health test, word handshake.
module trng_ctrl
   import trng_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned WARMUP     = 64,
   parameter int unsigned SAMPLE_DIV = 4,
   parameter int unsigned REP_LIMIT  = 32
) (
   input  logic       clk,
   input  logic       reset,
   trng_ctrl_if.slave bus
);

   localparam int unsigned WARM_W = cnt_w(WARMUP);
   localparam int unsigned DIV_W  = cnt_w(SAMPLE_DIV);
   localparam int unsigned BIT_W  = cnt_w(WIDTH);
   localparam int unsigned REP_W  = cnt_w(REP_LIMIT);

   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
   localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

   state_e            state_q, state_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [REP_W-1:0]  rep_q, rep_d, rep_nxt;
   logic              last_q, last_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              osc_q, osc_d;
   logic              valid_q, valid_d;
   logic              fault_q, fault_d;

   logic sample_stb, vn_clear, bit_stb, bit_out, rep_trip, word_done;

   assign sample_stb = (state_q == COLLECT) && (div_q == DIV_LAST);
   assign vn_clear   = (state_q != COLLECT);
   assign rep_nxt    = ((rep_q == '0) || (bus.rnd_bit != last_q)) ? REP_W'(1) : rep_q + REP_W'(1);
   assign rep_trip   = sample_stb && (rep_nxt == REP_MAX);
   assign word_done  = bit_stb && (bit_q == BIT_LAST);

   vn_debias u_vn (
      .clk        (clk),
      .reset      (reset),
      .clear      (vn_clear),
      .sample_stb (sample_stb),
      .sample     (bus.rnd_bit),
      .bit_stb    (bit_stb),
      .bit_out    (bit_out)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a health fault outranks both abort and word completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req) state_d = WARM;
         WARM: begin
            if (!bus.req)               state_d = IDLE;
            else if (warm_q == WARM_LAST) state_d = COLLECT;
         end
         COLLECT: begin
            if (rep_trip)       state_d = FAULT;
            else if (!bus.req)  state_d = IDLE;
            else if (word_done) state_d = HOLD;
         end
         HOLD:    if (bus.ack) state_d = bus.req ? WARM : IDLE;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the upcoming state so outputs register in step with it.
   always_comb begin
      osc_d   = (state_d == WARM) || (state_d == COLLECT);
      valid_d = (state_d == HOLD);
      fault_d = (state_d == FAULT);
   end

   // Counters, health test and word shift register; all restart on entry to WARM.
   always_comb begin
      warm_d = '0;
      div_d  = '0;
      bit_d  = bit_q;
      rep_d  = rep_q;
      last_d = last_q;
      data_d = data_q;
      if ((state_q == WARM) && (state_d == WARM)) warm_d = warm_q + WARM_W'(1);
      if ((state_q == COLLECT) && (state_d == COLLECT) && !sample_stb) div_d = div_q + DIV_W'(1);
      if ((state_d == WARM) && (state_q != WARM)) begin
         bit_d  = '0;
         rep_d  = '0;
         last_d = 1'b0;
         data_d = '0;
      end else if (state_q == COLLECT) begin
         if (sample_stb) begin
            rep_d  = rep_nxt;
            last_d = bus.rnd_bit;
         end
         if (bit_stb) begin
            bit_d  = bit_q + BIT_W'(1);
            data_d = {data_q[WIDTH-2:0], bit_out};
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         warm_q  <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         rep_q   <= '0;
         last_q  <= 1'b0;
         data_q  <= '0;
         osc_q   <= 1'b0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         warm_q  <= warm_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         rep_q   <= rep_d;
         last_q  <= last_d;
         data_q  <= data_d;
         osc_q   <= osc_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign bus.osc_en = osc_q;
   assign bus.valid  = valid_q;
   assign bus.fault  = fault_q;
   assign bus.data   = data_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Scoreboard bench for trng_ctrl: directed scenarios plus randomized words.
module tb_trng_ctrl;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned WARMUP     = 4;
   localparam int unsigned SAMPLE_DIV = 1;
   localparam int unsigned REP_LIMIT  = 32;

   typedef struct {
      logic [7:0] word;
      int         cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;
   bit   fault_ok;
   bit   raw_q[$];
   exp_t exp_q[$];

   trng_ctrl_if #(.WIDTH(WIDTH)) bus ();

   trng_ctrl #(
      .WIDTH      (WIDTH),
      .WARMUP     (WARMUP),
      .SAMPLE_DIV (SAMPLE_DIV),
      .REP_LIMIT  (REP_LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: von Neumann over raw pairs and repetition count over the raw stream.
   task automatic model(output logic [7:0] w, output int n_done, output int n_fault);
      int rep, emitted;
      bit last;
      w = '0; n_done = 0; n_fault = 0; rep = 0; emitted = 0; last = 1'b0;
      for (int k = 0; k < raw_q.size(); k++) begin
         if (k == 0 || raw_q[k] != last) rep = 1;
         else rep++;
         last = raw_q[k];
         if (rep == REP_LIMIT) begin
            n_fault = k + 1;
            return;
         end
         if ((k % 2) == 1 && raw_q[k-1] != raw_q[k]) begin
            w = {w[6:0], raw_q[k-1]};
            emitted++;
            if (emitted == WIDTH) begin
               n_done = k + 1;
               return;
            end
         end
      end
   endtask

   task automatic load_pairs(input logic [63:0] p, input int npairs);
      raw_q.delete();
      for (int i = 0; i < 2 * npairs; i++) raw_q.push_back(p[2*npairs-1-i]);
   endtask

   task automatic gen_random();
      logic [7:0] w;
      int nd, nf, cnt;
      bit a, b;
      do begin
         raw_q.delete();
         cnt = 0;
         while (cnt < WIDTH) begin
            a = 1'($urandom);
            b = 1'($urandom);
            raw_q.push_back(a);
            raw_q.push_back(b);
            if (a != b) cnt++;
         end
         model(w, nd, nf);
      end while (nf != 0);
   endtask

   // Called in the time step of the edge that entered WARM; returns at the
   // negedge following the last raw sample.
   task automatic feed(input bit push_exp, input bit use_lit, input logic [7:0] lit);
      logic [7:0] w;
      int nd, nf, c0, m, k;
      exp_t e;
      model(w, nd, nf);
      @(negedge clk);
      c0 = cyc;
      chk("warm_osc", 32'(bus.osc_en), 32'd1);
      chk("warm_valid", 32'(bus.valid), 32'd0);
      if (push_exp) begin
         e.word = use_lit ? lit : w;
         e.cyc  = c0 + WARMUP + nd * SAMPLE_DIV;
         exp_q.push_back(e);
      end
      m = 0;
      k = 0;
      while (k < raw_q.size()) begin
         if (m >= WARMUP && ((m - WARMUP + 1) % SAMPLE_DIV) == 0) begin
            bus.rnd_bit = raw_q[k];
            k++;
         end else begin
            bus.rnd_bit = ~raw_q[k];
         end
         bus.ack = 1'($urandom);
         @(posedge clk);
         m++;
         @(negedge clk);
         if (k < raw_q.size()) chk("collect_osc", 32'(bus.osc_en), 32'd1);
      end
      bus.ack = 1'b0;
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!bus.valid && t < 8) begin
         @(negedge clk);
         t++;
      end
      chk("valid_seen", 32'(bus.valid), 32'd1);
   endtask

   // Sit in HOLD a little (req may wobble), then ack; b2b keeps req high.
   task automatic hold_ack(input bit b2b);
      int n;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
         bus.req = 1'($urandom);
         @(negedge clk);
      end
      chk("hold_valid", 32'(bus.valid), 32'd1);
      chk("hold_osc", 32'(bus.osc_en), 32'd0);
      bus.ack = 1'b1;
      bus.req = b2b;
      @(posedge clk);
      if (!b2b) begin
         @(negedge clk);
         bus.ack = 1'b0;
         chk("ack_valid", 32'(bus.valid), 32'd0);
         chk("ack_osc", 32'(bus.osc_en), 32'd0);
      end
   endtask

   // Monitor: pops the scoreboard whenever a new word is presented.
   initial begin
      bit vp;
      logic [7:0] dp;
      exp_t e;
      vp = 1'b0;
      dp = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            vp = 1'b0;
         end else begin
            if (bus.valid && !vp) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid actual=%0h required=none (cycle %0d)", bus.data, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("word_data", 32'(bus.data), 32'(e.word));
                  chk("word_cycle", 32'(cyc), 32'(e.cyc));
                  chk("word_osc", 32'(bus.osc_en), 32'd0);
               end
            end else if (bus.valid && vp) begin
               chk("hold_stable", 32'(bus.data), 32'(dp));
            end
            if (!fault_ok) chk("no_fault", 32'(bus.fault), 32'd0);
            vp = bus.valid;
            dp = bus.data;
         end
      end
   end

   initial begin
      int c0, target;
      bit b2b;
      checks = 0; errors = 0; fault_ok = 1'b0;
      reset = 1'b1;
      bus.req = 1'b1; bus.ack = 1'b0; bus.rnd_bit = 1'b0;

      // Reset with req held high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_osc", 32'(bus.osc_en), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_fault", 32'(bus.fault), 32'd0);
      chk("rst_data", 32'(bus.data), 32'd0);
      reset = 1'b0;
      @(posedge clk);

      // Word assembly, then back-to-back into the discard scenario.
      load_pairs(64'h9966, 8);
      feed(1'b1, 1'b1, 8'hA5);
      wait_valid();
      hold_ack(1'b1);
      load_pairs(64'h21E1D2D2, 15);
      feed(1'b1, 1'b1, 8'hA5);
      wait_valid();
      hold_ack(1'b0);

      // Abort after 5 emitted bits, then a fresh word.
      bus.req = 1'b1;
      @(posedge clk);
      load_pairs(64'h2AA, 5);
      feed(1'b0, 1'b0, 8'h00);
      chk("abort_pre_osc", 32'(bus.osc_en), 32'd1);
      bus.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_osc", 32'(bus.osc_en), 32'd0);
      chk("abort_valid", 32'(bus.valid), 32'd0);
      bus.req = 1'b1;
      @(posedge clk);
      load_pairs(64'h5AA5, 8);
      feed(1'b1, 1'b1, 8'h3C);
      wait_valid();
      hold_ack(1'b0);

      // Randomized words with random ack latency and back-to-back requests.
      b2b = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!b2b) begin
            bus.req = 1'b1;
            @(posedge clk);
         end
         gen_random();
         feed(1'b1, 1'b0, 8'h00);
         wait_valid();
         b2b = (i < 19) ? 1'($urandom) : 1'b0;
         hold_ack(b2b);
      end

      // Health fault: constant input trips at raw sample REP_LIMIT.
      bus.req = 1'b1;
      bus.rnd_bit = 1'b1;
      @(posedge clk);
      @(negedge clk);
      c0 = cyc;
      target = c0 + WARMUP + REP_LIMIT * SAMPLE_DIV;
      while (cyc < target - 1) @(negedge clk);
      chk("pre_fault", 32'(bus.fault), 32'd0);
      fault_ok = 1'b1;
      @(negedge clk);
      chk("fault_set", 32'(bus.fault), 32'd1);
      chk("fault_osc", 32'(bus.osc_en), 32'd0);
      chk("fault_valid", 32'(bus.valid), 32'd0);
      for (int i = 0; i < 12; i++) begin
         bus.req = 1'($urandom);
         bus.ack = 1'($urandom);
         @(negedge clk);
         chk("fault_sticky", 32'(bus.fault), 32'd1);
         chk("fault_novalid", 32'(bus.valid), 32'd0);
         chk("fault_noosc", 32'(bus.osc_en), 32'd0);
      end

      // Only reset clears the fault.
      bus.req = 1'b0;
      bus.ack = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst2_fault", 32'(bus.fault), 32'd0);
      chk("rst2_osc", 32'(bus.osc_en), 32'd0);
      chk("rst2_data", 32'(bus.data), 32'd0);
      fault_ok = 1'b0;
      reset = 1'b0;

      bus.req = 1'b1;
      @(posedge clk);
      gen_random();
      feed(1'b1, 1'b0, 8'h00);
      wait_valid();
      hold_ack(1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trng_ctrl.md
# trng_ctrl

Sequencing controller for the GARO true-random source in the dice roller. It enables the ring oscillator only while a random word is being produced and waits out a warm-up period. It then samples the synchronized random bit at a fixed rate, removes bias with a von Neumann corrector, runs a repetition-count health test, and delivers a WIDTH-bit word through a valid/ack handshake to the roll logic.

## Interface
- WIDTH, 8: output word width, ≥2.
- WARMUP, 64: cycles the oscillator runs before sampling starts, ≥1.
- SAMPLE_DIV, 4: clock cycles between raw samples, ≥1.
- REP_LIMIT, 32: consecutive identical raw samples that trip the health fault, ≥2.

- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  level request for random words.
- rnd_bit  in  1  GARO output, already passed through its 2-FF synchronizer.
- osc_en  out  1  drives the GARO stop pin: 1 = oscillate, 0 = frozen.
- data  out  WIDTH  random word; stable while valid=1.
- valid  out  1  data available.
- ack  in  1  consumer takes data; meaningful only while valid=1.
- fault  out  1  sticky health-test failure.

## Operation
- States: IDLE, WARM, COLLECT, HOLD, FAULT. All outputs are registered.
- IDLE: osc_en=0, valid=0.
  - req=1 → WARM. Warm-up counter, sample divider, pair flag, bit count and repetition counter are cleared.
- WARM: osc_en=1. Lasts exactly WARMUP cycles, then → COLLECT. rnd_bit is ignored here, which also flushes the synchronizer.
- COLLECT: osc_en=1. The divider counts 0..SAMPLE_DIV-1; a raw sample of rnd_bit is taken on each terminal count.
  - Von Neumann corrector, applied to non-overlapping raw pairs:
    - 1st sample of a pair is stored.
    - 2nd sample: pair 10 emits 1, pair 01 emits 0, pairs 00 and 11 are discarded. The pair flag always resets.
    - An emitted bit shifts in as data <= {data[WIDTH-2:0], bit}, so the first bit ends at the MSB.
  - The word is complete at the WIDTH-th emitted bit → HOLD.
  - Health test: a repetition counter tracks consecutive equal raw samples, independent of pair boundaries.
    - The first sample of a COLLECT visit sets it to 1.
    - An equal sample increments it; a differing sample sets it to 1.
    - Reaching REP_LIMIT → FAULT.
- HOLD: osc_en=0, valid=1, data frozen.
  - ack=1 & req=1 → WARM.
  - ack=1 & req=0 → IDLE.
  - The oscillator is always re-warmed after being frozen.
- FAULT: osc_en=0, valid=0, fault=1. Only reset exits this state; req and ack are ignored.
- Abort: req=0 during WARM or COLLECT → IDLE next cycle. The partial word, bit count and pair flag are discarded, so later words never mix old bits.
- Ack outside HOLD is ignored. Dropping req while in HOLD does not retract valid.

## Timing
- Reset values: osc_en=0, data=0, valid=0, fault=0, state=IDLE, all counters 0.
- req sampled high in IDLE at cycle t → osc_en=1 at t+1. WARM occupies t+1..t+WARMUP.
- The first raw sample is taken in the SAMPLE_DIV-th COLLECT cycle. Raw sample k (k≥1) falls in COLLECT cycle k·SAMPLE_DIV.
- The cycle after the sample that emits the WIDTH-th bit: valid=1, osc_en=0, final data visible.
- ack in HOLD → valid=0 and state change on the next cycle.
- Repetition counter reaching REP_LIMIT at a sample → fault=1 and osc_en=0 on the next cycle.
  - Fault takes priority over word completion if both occur on the same sample; valid stays 0.
- req drop during WARM or COLLECT → osc_en=0 on the next cycle.
- Counter widths: $clog2 of the respective parameter plus 1. No counter wraps; each is cleared on state entry.

## Structure
- Package trng_pkg holds:
  - the state enum {IDLE, WARM, COLLECT, HOLD, FAULT};
  - a width helper function for the counters.
- Sub-module vn_debias:
  - inputs: clk, reset, clear, sample_stb, sample;
  - outputs: bit_stb, bit_out.
  - It holds the pair register and pair flag. The controller owns the FSM, counters, health test and shift register.

## Test plan
- Reset: assert reset for 2 cycles with req=1 → osc_en, valid, fault, data all 0; state IDLE the cycle after release.
- Word assembly (WIDTH=8, WARMUP=4, SAMPLE_DIV=1, REP_LIMIT=32):
  - Stimulus: req=1; raw pairs 10,01,10,01,01,10,01,10.
  - Required: data=8'hA5. valid=1 the cycle after the 16th sample, with osc_en=0 in the same cycle.
- Discard: interleave pairs 00 and 11 between the pairs of the word-assembly scenario → same data=8'hA5. Valid is delayed by 2 cycles per discarded pair.
- Health fault: rnd_bit held 1, REP_LIMIT=32 → fault=1 the cycle after raw sample 32; valid never asserts; pulsing req/ack leaves fault=1 until reset.
- Abort: drop req after 5 emitted bits → osc_en=0 next cycle. A new req then produces a word built only from the new samples; drive pattern 8'h3C and check 8'h3C.
- Back-to-back: in HOLD, ack=1 with req=1 → valid=0 next cycle, osc_en=1, full WARMUP before the first new sample; a second word is delivered correctly.
